// File: rtl/uart_frame_loader.sv
// uart_frame_loader: pops ASCII '0'/'1' characters from the uart_top RX FIFO,
// assembles them LSB-first into an NBITS-wide frame and holds the frame under
// a valid/ack handshake. Whitespace (space, CR, LF) is skipped. Any other
// character sets a sticky error flag.
// Build option: define UART_LOADER_ECHO_EN to echo each accepted bit
// character back to the TX FIFO, stalling while tx_full is high.
//
// state | meaning
// IDLE  | waiting for a byte at the RX FIFO head
// FETCH | popping the head byte and consuming it
// ECHO  | waiting for TX space, then pushing the accepted byte (echo build only)
// DONE  | frame complete and frozen until frame_ack or clear
module uart_frame_loader #(
  parameter int NBITS = 66
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         rx_empty,
  input  logic [7:0]                   read_data,
  input  logic                         tx_full,
  output logic                         read_uart,
  output logic                         write_uart,
  output logic [7:0]                   write_data,
  output logic [NBITS-1:0]             frame,
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic [$clog2(NBITS+1)-1:0]   bit_count,
  output logic                         err,
  output logic                         busy
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

`ifdef UART_LOADER_ECHO_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2, ECHO = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t           state_q;
  logic [NBITS-1:0] frame_q;
  logic [CW-1:0]    bit_count_q;
  logic [CW-1:0]    bit_count_d;
  logic             frame_valid_q;
  logic             err_q;
  logic             is_bit;
  logic             is_ws;

`ifdef UART_LOADER_ECHO_EN
  logic             write_uart_q;
  logic [7:0]       write_data_q;
`else
  logic             unused_tx_full;
  assign unused_tx_full = tx_full;
`endif

  // Classify the FIFO head byte and form the saturating bit counter increment.
  always_comb begin
    is_bit      = (read_data == 8'h30) || (read_data == 8'h31);
    is_ws       = (read_data == 8'h20) || (read_data == 8'h0D) || (read_data == 8'h0A);
    bit_count_d = (bit_count_q < FULL) ? bit_count_q + CW'(1) : bit_count_q;
  end

  // Sequencer: state, frame assembly, handshake and registered strobes.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      bit_count_q   <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef UART_LOADER_ECHO_EN
      write_uart_q  <= 1'b0;
      write_data_q  <= 8'h00;
`endif
    end else if (clear) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      bit_count_q   <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef UART_LOADER_ECHO_EN
      write_uart_q  <= 1'b0;
`endif
    end else begin
`ifdef UART_LOADER_ECHO_EN
      write_uart_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_empty) state_q <= FETCH;
        end
        FETCH: begin
          if (is_bit) begin
            if (bit_count_q < FULL) begin
              frame_q[bit_count_q] <= read_data[0];
              bit_count_q          <= bit_count_d;
            end
          end else if (!is_ws) begin
            err_q <= 1'b1;
          end
`ifdef UART_LOADER_ECHO_EN
          if (is_bit) begin
            write_data_q <= read_data;
            state_q      <= ECHO;
          end else begin
            state_q <= IDLE;
          end
`else
          if (is_bit && bit_count_q == LAST) begin
            frame_valid_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            state_q <= IDLE;
          end
`endif
        end
`ifdef UART_LOADER_ECHO_EN
        ECHO: begin
          if (!tx_full) begin
            write_uart_q <= 1'b1;
            if (bit_count_q == FULL) begin
              frame_valid_q <= 1'b1;
              state_q       <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
`endif
        DONE: begin
          if (frame_ack) begin
            frame_valid_q <= 1'b0;
            bit_count_q   <= '0;
            err_q         <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_uart   = (state_q == FETCH);
  assign busy        = (state_q != IDLE);
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign bit_count   = bit_count_q;
  assign err         = err_q;
`ifdef UART_LOADER_ECHO_EN
  assign write_uart  = write_uart_q;
  assign write_data  = write_data_q;
`else
  assign write_uart  = 1'b0;
  assign write_data  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader with a simple RX FIFO model.
module tb_uart_frame_loader;
  localparam int NBITS = 66;
  localparam int CW    = $clog2(NBITS + 1);
`ifdef UART_LOADER_ECHO_EN
  localparam int FRAME_CYC = 198;
`else
  localparam int FRAME_CYC = 132;
`endif

  logic             CLK = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear = 1'b0;
  logic             rx_empty;
  logic [7:0]       read_data;
  logic             tx_full = 1'b0;
  logic             read_uart;
  logic             write_uart;
  logic [7:0]       write_data;
  logic [NBITS-1:0] frame;
  logic             frame_valid;
  logic             frame_ack = 1'b0;
  logic [CW-1:0]    bit_count;
  logic             err;
  logic             busy;

  logic [7:0] mem [0:1023];
  int         wp = 0;
  int         rp = 0;
  int         pop_cnt = 0;
  int         wr_cnt = 0;
  logic [7:0] last_wd = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  uart_frame_loader #(.NBITS(NBITS)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .clear      (clear),
    .rx_empty   (rx_empty),
    .read_data  (read_data),
    .tx_full    (tx_full),
    .read_uart  (read_uart),
    .write_uart (write_uart),
    .write_data (write_data),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .bit_count  (bit_count),
    .err        (err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  assign rx_empty  = (rp == wp);
  assign read_data = mem[rp[9:0]];

  // FIFO model: pop on read_uart, log TX pushes
  always @(posedge CLK) begin
    if (read_uart === 1'b1) begin
      rp      <= rp + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (write_uart === 1'b1) begin
      wr_cnt  <= wr_cnt + 1;
      last_wd <= write_data;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[9:0]] = b;
    wp = wp + 1;
  endtask

  task automatic push_alt(input int n, input logic [7:0] b_even, input logic [7:0] b_odd);
    for (int i = 0; i < n; i++) push(((i % 2) == 0) ? b_even : b_odd);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!frame_valid && cyc < 400);
    chk("frame_valid_timeout", frame_valid, 1'b1);
  endtask

  int base;
  int cyc;
  int w0;

  initial begin
    // reset with data waiting: nothing may be popped
    #1 reset_n = 1'b0;
    push(8'h20);
    cycles(4);
    chk("rst_read_uart", read_uart, 1'b0);
    chk("rst_write_uart", write_uart, 1'b0);
    chk("rst_write_data", write_data, 8'h00);
    chk("rst_frame", frame, '0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_no_pop", pop_cnt, 0);
    reset_n = 1'b1;
    cycles(6);
    chk("space_popped", pop_cnt, 1);
    chk("space_ignored_cnt", bit_count, 0);
    chk("space_ignored_err", err, 1'b0);

    // full alternating frame "1","0",... with two trailing spaces held back
    base = pop_cnt;
    push_alt(66, 8'h31, 8'h30);
    push(8'h20);
    push(8'h20);
    wait_frame(cyc);
    chk("alt_latency", cyc, FRAME_CYC);
    chk("alt_frame", frame, 66'h15555555555555555);
    chk("alt_bit_count", bit_count, 66);
    cycles(10);
    chk("alt_pops", pop_cnt - base, 66);
    chk("alt_held_valid", frame_valid, 1'b1);
    chk("alt_backpressure", rx_empty, 1'b0);
    chk("alt_frozen", frame, 66'h15555555555555555);
`ifdef UART_LOADER_ECHO_EN
    chk("alt_echo_count", wr_cnt, 66);
    chk("alt_echo_last", last_wd, 8'h30);
`else
    chk("no_echo_writes", wr_cnt, 0);
`endif
    frame_ack = 1'b1;
    cycles(1);
    frame_ack = 1'b0;
    chk("ack_valid", frame_valid, 1'b0);
    chk("ack_bit_count", bit_count, 0);
    chk("ack_busy", busy, 1'b0);
    chk("ack_frame_kept", frame, 66'h15555555555555555);
    cycles(10);
    chk("ack_drained", rx_empty, 1'b1);
    chk("ack_frame_kept2", frame, 66'h15555555555555555);

    // mixed stream: bit, LF, illegal, bit
    push(8'h31);
    push(8'h0A);
    push(8'h78);
    push(8'h30);
    cycles(20);
    chk("mix_bit_count", bit_count, 2);
    chk("mix_frame_lo", frame[1:0], 2'b01);
    chk("mix_err", err, 1'b1);
    chk("mix_valid", frame_valid, 1'b0);
    cycles(10);
    chk("mix_err_sticky", err, 1'b1);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    chk("clr_frame", frame, '0);
    chk("clr_bit_count", bit_count, 0);
    chk("clr_err", err, 1'b0);

`ifdef UART_LOADER_ECHO_EN
    // echo stall on tx_full
    tx_full = 1'b1;
    w0 = wr_cnt;
    push(8'h31);
    cycles(12);
    chk("stall_no_write", wr_cnt, w0);
    chk("stall_busy", busy, 1'b1);
    chk("stall_bit_count", bit_count, 1);
    tx_full = 1'b0;
    cycles(4);
    chk("stall_one_write", wr_cnt, w0 + 1);
    chk("stall_write_data", last_wd, 8'h31);
    chk("stall_idle", busy, 1'b0);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
`endif

    // clear and ack together in DONE: clear wins
    push_alt(66, 8'h31, 8'h31);
    wait_frame(cyc);
    chk("ones_frame", frame, 66'h3FFFFFFFFFFFFFFFF);
    clear = 1'b1;
    frame_ack = 1'b1;
    cycles(1);
    clear = 1'b0;
    frame_ack = 1'b0;
    chk("clrack_frame", frame, '0);
    chk("clrack_bit_count", bit_count, 0);
    chk("clrack_valid", frame_valid, 1'b0);
    chk("clrack_busy", busy, 1'b0);

    // reset mid-frame, then a fresh frame
    push_alt(30, 8'h31, 8'h31);
    cycles(100);
    chk("mid_bit_count", bit_count, 30);
    reset_n = 1'b0;
    cycles(2);
    chk("mid_rst_bit_count", bit_count, 0);
    chk("mid_rst_frame", frame, '0);
    chk("mid_rst_read_uart", read_uart, 1'b0);
    reset_n = 1'b1;
    push_alt(66, 8'h30, 8'h31);
    wait_frame(cyc);
    chk("fresh_latency", cyc, FRAME_CYC);
    chk("fresh_frame", frame, 66'h2AAAAAAAAAAAAAAAA);
    chk("fresh_bit_count", bit_count, 66);
    frame_ack = 1'b1;
    cycles(1);
    frame_ack = 1'b0;
    chk("fresh_ack_valid", frame_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
